// File: rtl/updown_counter_ps.sv
// updown_counter_ps
//   Up/down counter with a built-in prescaler. Everything runs on clk. The
//   prescaler produces a one-cycle step enable every PRESCALE cycles while
//   en is high. The counter supports a synchronous load, and at its limits
//   it either wraps or saturates. All outputs are registered.
//
//   Optional feature macro: UPDN_CNT_CMP_EN (registered compare against cmp_val).
//
// Parameters
//   WIDTH     counter width in bits (>= 2)
//   PRESCALE  clk cycles per count step (>= 1)
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   en         in   count enable; the prescaler runs only while high
//   dir        in   1 = count up, 0 = count down
//   sat_mode   in   1 = saturate at limits, 0 = wrap
//   load       in   synchronous load strobe (overrides a step)
//   load_val   in   value written by load
//   cmp_val    in   compare value (only used with UPDN_CNT_CMP_EN)
//   q          out  counter value
//   tick       out  one-cycle pulse: a step was taken on this edge
//   tc         out  one-cycle pulse: a step hit a limit
//   cmp_match  out  level: q == cmp_val (0 without UPDN_CNT_CMP_EN)
module updown_counter_ps #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned PRESCALE = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             tc,
    output logic             cmp_match
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    r_pcnt;
    logic [WIDTH-1:0] r_q;
    logic             r_tick;
    logic             r_tc;

    logic             w_step;
    logic             w_limit;
    logic             w_tc_next;
    logic [WIDTH-1:0] w_q_next;

    always_comb begin
        w_step    = en && (r_pcnt == P_LAST);
        w_limit   = dir ? (r_q == '1) : (r_q == '0);
        w_q_next  = r_q;
        w_tc_next = 1'b0;
        if (load) begin
            w_q_next = load_val;
        end else if (w_step) begin
            w_tc_next = w_limit;
            // A saturated step still counts as a step (tick), but q holds.
            if (!(w_limit && sat_mode)) begin
                if (dir) w_q_next = r_q + WIDTH'(1);
                else     w_q_next = r_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt <= '0;
            r_q    <= '0;
            r_tick <= 1'b0;
            r_tc   <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_tick <= w_step && !load;
            r_tc   <= w_tc_next;
            // A partial period is discarded on disable or load.
            if (!en || load || w_step) r_pcnt <= '0;
            else                       r_pcnt <= r_pcnt + PW'(1);
        end
    end

`ifdef UPDN_CNT_CMP_EN
    logic r_cmp;

    // Compares against the next q so that the match is valid alongside the new q.
    always_ff @(posedge clk) begin
        if (rst) r_cmp <= 1'b0;
        else     r_cmp <= (w_q_next == cmp_val);
    end

    assign cmp_match = r_cmp;
`else
    logic w_unused_cmp;
    assign w_unused_cmp = ^cmp_val;
    assign cmp_match    = 1'b0;
`endif

    assign q    = r_q;
    assign tick = r_tick;
    assign tc   = r_tc;

endmodule

// File: tb/tb_updown_counter_ps.sv
module tb_updown_counter_ps;

    localparam int unsigned W  = 8;
    localparam int unsigned PS = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         dir;
    logic         sat_mode;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] cmp_val;
    logic [W-1:0] q;
    logic         tick;
    logic         tc;
    logic         cmp_match;

    updown_counter_ps #(.WIDTH(W), .PRESCALE(PS)) dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .sat_mode(sat_mode),
        .load(load), .load_val(load_val), .cmp_val(cmp_val),
        .q(q), .tick(tick), .tc(tc), .cmp_match(cmp_match)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] q;
        logic       tc;
    } step_t;

    step_t sb[$];
    int    cyc = 0;
    int    n_chk = 0;
    int    n_pass = 0;
    bit    done = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk = n_chk + 1;
        if (act == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tk(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int n, input logic [7:0] eq, input logic etc);
        step_t s;
        s.cyc = cyc + n;
        s.q   = eq;
        s.tc  = etc;
        sb.push_back(s);
    endtask

    // Monitor: every tick pulse must match the next expected step.
    initial begin
        step_t s;
        forever begin
            @(negedge clk);
            if (done) break;
            if (tick) begin
                if (sb.size() == 0) begin
                    chk("unexpected_tick", 1, 0);
                end else begin
                    s = sb.pop_front();
                    chk("step_cycle", cyc, s.cyc);
                    chk("step_q", int'(q), int'(s.q));
                    chk("step_tc", int'(tc), int'(s.tc));
                end
            end else begin
                if (tc) chk("tc_without_tick", 1, 0);
                if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                    s = sb.pop_front();
                    chk("missed_step_at", cyc, s.cyc + 1000);
                end
            end
        end
    end

    initial begin
        int exp_cmp;
        rst = 1'b1; en = 1'b0; dir = 1'b1; sat_mode = 1'b0;
        load = 1'b0; load_val = '0; cmp_val = '0;

        // Reset and first steps
        tk(2);
        chk("rst_q", int'(q), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_tc", int'(tc), 0);
        chk("rst_cmp", int'(cmp_match), 0);
        rst = 1'b0; en = 1'b1; dir = 1'b1;
        push(4, 8'h01, 1'b0);
        push(8, 8'h02, 1'b0);
        push(12, 8'h03, 1'b0);
        tk(12);
        chk("first_q3", int'(q), 3);

        // Wrap up
        load = 1'b1; load_val = 8'hFE;
        tk();
        chk("load_fe_q", int'(q), 8'hFE);
        chk("load_fe_tick", int'(tick), 0);
        load = 1'b0; sat_mode = 1'b0;
        push(4, 8'hFF, 1'b0);
        push(8, 8'h00, 1'b1);
        tk(8);

        // Wrap down
        dir = 1'b0; load = 1'b1; load_val = 8'h01;
        tk();
        load = 1'b0;
        push(4, 8'h00, 1'b0);
        push(8, 8'hFF, 1'b1);
        tk(8);

        // Saturate up
        dir = 1'b1; sat_mode = 1'b1; load = 1'b1; load_val = 8'hFE;
        tk();
        load = 1'b0;
        push(4, 8'hFF, 1'b0);
        push(8, 8'hFF, 1'b1);
        push(12, 8'hFF, 1'b1);
        tk(12);

        // Load coinciding with a step
        sat_mode = 1'b0;
        tk(3);
        load = 1'b1; load_val = 8'h40;
        tk();
        chk("ld_step_q", int'(q), 8'h40);
        chk("ld_step_tick", int'(tick), 0);
        chk("ld_step_tc", int'(tc), 0);
        load = 1'b0;
        push(4, 8'h41, 1'b0);
        tk(4);

        // Enable gap at pcnt = 2
        tk(2);
        en = 1'b0;
        tk(3);
        chk("gap_q", int'(q), 8'h41);
        en = 1'b1;
        push(4, 8'h42, 1'b0);
        tk(4);

        // Compare window while counting up from 0
        en = 1'b0; load = 1'b1; load_val = 8'h00; cmp_val = 8'h05;
        tk();
        load = 1'b0; en = 1'b1;
        for (int j = 1; j <= 6; j++) push(4 * j, 8'(j), 1'b0);
        for (int k = 1; k <= 24; k++) begin
            tk();
`ifdef UPDN_CNT_CMP_EN
            exp_cmp = (k >= 20 && k <= 23) ? 1 : 0;
`else
            exp_cmp = 0;
`endif
            chk($sformatf("cmp_k%0d", k), int'(cmp_match), exp_cmp);
        end

        // Reset mid-period overrides load
        tk(2);
        rst = 1'b1; load = 1'b1; load_val = 8'h77;
        tk();
        chk("midrst_q", int'(q), 0);
        chk("midrst_tick", int'(tick), 0);
        rst = 1'b0; load = 1'b0; en = 1'b0;
        tk(3);

        chk("scoreboard_empty", sb.size(), 0);
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "timeout");
    end

endmodule
